// File: rtl/interface_demux_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : interface_demux_tx_if
//  Description : Bundle of the backend frame/pointer FIFO read side and the
//                four MAC TX data/pointer FIFO write side seen by
//                interface_demux_tx.
//                master : the demux (pops backend FIFOs, writes TX FIFOs)
//                slave  : the FIFO/MAC environment around it
//  Ports       : ptr_fifo_empty/rd/dout   backend descriptor FIFO
//                data_fifo_rd/dout        backend byte FIFO
//                tx_rdy[3:0]              per-port room for a full frame
//                tx_data_fifo_wr/din      per-port byte write, shared byte
//                tx_ptr_fifo_wr/din       per-port descriptor write, shared
//  Revision    : 1.0  initial release
// ============================================================================
interface interface_demux_tx_if;
  logic        ptr_fifo_empty;
  logic        ptr_fifo_rd;
  logic [15:0] ptr_fifo_dout;
  logic        data_fifo_rd;
  logic [7:0]  data_fifo_dout;
  logic [3:0]  tx_rdy;
  logic [3:0]  tx_data_fifo_wr;
  logic [7:0]  tx_data_fifo_din;
  logic [3:0]  tx_ptr_fifo_wr;
  logic [15:0] tx_ptr_fifo_din;

  modport master (
    input  ptr_fifo_empty, ptr_fifo_dout, data_fifo_dout, tx_rdy,
    output ptr_fifo_rd, data_fifo_rd, tx_data_fifo_wr, tx_data_fifo_din,
           tx_ptr_fifo_wr, tx_ptr_fifo_din
  );

  modport slave (
    output ptr_fifo_empty, ptr_fifo_dout, data_fifo_dout, tx_rdy,
    input  ptr_fifo_rd, data_fifo_rd, tx_data_fifo_wr, tx_data_fifo_din,
           tx_ptr_fifo_wr, tx_ptr_fifo_din
  );
endinterface
`default_nettype wire

// File: rtl/interface_demux_tx.sv
`default_nettype none
// ============================================================================
//  Module      : interface_demux_tx
//  Description : Egress demux. Pops a frame descriptor and its bytes from the
//                switch-core backend FIFOs and writes the frame into the TX
//                data/pointer FIFOs of every MAC port selected by the
//                descriptor's port mask. Bad descriptors (err, empty mask,
//                oversize) are drained without any TX writes and counted.
//  Ports       : clk_sys    system clock, rising edge
//                rst_sys    asynchronous active-high reset
//                bus        interface_demux_tx_if.master (FIFO/TX signals)
//                busy       high whenever the FSM is not idle
//                drop_cnt   saturating count of dropped descriptors
//  Revision    : 1.0  initial release
// ============================================================================
module interface_demux_tx #(
  parameter int LEN_W   = 11,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  wire logic             clk_sys,
  input  wire logic             rst_sys,
  interface_demux_tx_if.master  bus,
  output logic                  busy,
  output logic [CNT_W-1:0]      drop_cnt
);

  localparam logic [LEN_W:0] C_MAX_LEN = (LEN_W+1)'(MAX_LEN);

  typedef enum logic [6:0] {
    S_IDLE    = 7'b0000001,
    S_PTR_RD  = 7'b0000010,
    S_PTR_LAT = 7'b0000100,
    S_WAIT    = 7'b0001000,
    S_DATA    = 7'b0010000,
    S_TAIL    = 7'b0100000,
    S_PTR_WR  = 7'b1000000
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         mask_q, mask_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               drop_q, drop_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               ptr_rd_q, ptr_rd_d;
  logic               data_rd_q, data_rd_d;
  logic               vld_q, vld_d;
  logic [3:0]         tx_data_wr_q, tx_data_wr_d;
  logic [7:0]         tx_data_din_q, tx_data_din_d;
  logic [3:0]         tx_ptr_wr_q, tx_ptr_wr_d;
  logic [15:0]        tx_ptr_din_q, tx_ptr_din_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               drop_evt;

  // Descriptor fields as presented by the backend FIFO on the latch cycle
  logic               w_desc_err;
  logic [3:0]         w_desc_mask;
  logic [LEN_W-1:0]   w_desc_len;
  logic               w_desc_drop;

  assign w_desc_err  = bus.ptr_fifo_dout[15];
  assign w_desc_mask = bus.ptr_fifo_dout[14:11];
  assign w_desc_len  = bus.ptr_fifo_dout[LEN_W-1:0];
  assign w_desc_drop = w_desc_err || (w_desc_mask == 4'b0000) ||
                       ({1'b0, w_desc_len} > C_MAX_LEN);

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    len_d    = len_q;
    drop_d   = drop_q;
    cnt_d    = cnt_q;
    drop_evt = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!bus.ptr_fifo_empty) state_d = S_PTR_RD;
      end
      S_PTR_RD: begin
        state_d = S_PTR_LAT;
      end
      S_PTR_LAT: begin
        mask_d = w_desc_mask;
        len_d  = w_desc_len;
        drop_d = w_desc_drop;
        cnt_d  = w_desc_len;
        if (w_desc_len == '0) begin
          // Nothing to drain: counted as a drop and finished right here.
          state_d  = S_IDLE;
          drop_evt = 1'b1;
        end else if (w_desc_drop) begin
          // Dropped frames still drain their bytes; port readiness is moot.
          state_d = S_DATA;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Every selected port must be ready; no partial multicast.
        if ((bus.tx_rdy & mask_q) == mask_q) state_d = S_DATA;
      end
      S_DATA: begin
        // cnt stays at 1 on exit so TAIL can count its two cycles 1 -> 0.
        if (cnt_q == LEN_W'(1)) state_d = S_TAIL;
        else                    cnt_d   = cnt_q - LEN_W'(1);
      end
      S_TAIL: begin
        if (cnt_q == '0) begin
          if (drop_q) begin
            state_d  = S_IDLE;
            drop_evt = 1'b1;
          end else begin
            state_d = S_PTR_WR;
          end
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      S_PTR_WR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are decoded from the next state so that, once registered,
    // they line up exactly with the cycles spent in the matching state.
    ptr_rd_d     = (state_d == S_PTR_RD);
    data_rd_d    = (state_d == S_DATA);
    busy_d       = (state_d != S_IDLE);
    tx_ptr_wr_d  = (state_d == S_PTR_WR) ? mask_q : 4'b0000;
    tx_ptr_din_d = (state_d == S_PTR_WR) ? {{(16-LEN_W){1'b0}}, len_q}
                                         : tx_ptr_din_q;

    // Byte pipeline: rd registered at t, dout valid at t+1, write at t+2.
    vld_d         = data_rd_q;
    tx_data_wr_d  = (vld_q && !drop_q) ? mask_q : 4'b0000;
    tx_data_din_d = vld_q ? bus.data_fifo_dout : tx_data_din_q;

    drop_cnt_d = drop_cnt_q;
    if (drop_evt && (drop_cnt_q != {CNT_W{1'b1}}))
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      len_q         <= '0;
      drop_q        <= 1'b0;
      cnt_q         <= '0;
      ptr_rd_q      <= 1'b0;
      data_rd_q     <= 1'b0;
      vld_q         <= 1'b0;
      tx_data_wr_q  <= '0;
      tx_data_din_q <= '0;
      tx_ptr_wr_q   <= '0;
      tx_ptr_din_q  <= '0;
      busy_q        <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      len_q         <= len_d;
      drop_q        <= drop_d;
      cnt_q         <= cnt_d;
      ptr_rd_q      <= ptr_rd_d;
      data_rd_q     <= data_rd_d;
      vld_q         <= vld_d;
      tx_data_wr_q  <= tx_data_wr_d;
      tx_data_din_q <= tx_data_din_d;
      tx_ptr_wr_q   <= tx_ptr_wr_d;
      tx_ptr_din_q  <= tx_ptr_din_d;
      busy_q        <= busy_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign bus.ptr_fifo_rd      = ptr_rd_q;
  assign bus.data_fifo_rd     = data_rd_q;
  assign bus.tx_data_fifo_wr  = tx_data_wr_q;
  assign bus.tx_data_fifo_din = tx_data_din_q;
  assign bus.tx_ptr_fifo_wr   = tx_ptr_wr_q;
  assign bus.tx_ptr_fifo_din  = tx_ptr_din_q;
  assign busy                 = busy_q;
  assign drop_cnt             = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_interface_demux_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interface_demux_tx
//  Description : Self-checking bench for interface_demux_tx. Backend FIFOs
//                are modelled with queues; expected per-port byte streams,
//                descriptor writes and drop counts are derived from each
//                pushed descriptor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_interface_demux_tx;

  localparam int TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                busy;
  logic [TB_CNT_W-1:0] drop_cnt;

  interface_demux_tx_if bus();

  interface_demux_tx #(.LEN_W(11), .MAX_LEN(1518), .CNT_W(TB_CNT_W)) dut (
    .clk_sys  (clk),
    .rst_sys  (rst),
    .bus      (bus),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int underflow = 0;

  logic [15:0] pq[$];
  logic [7:0]  dq[$];
  logic [7:0]  exp_bytes[4][$];
  logic [15:0] exp_ptr[4][$];
  logic [7:0]  rx_bytes[4][$];
  logic [15:0] rx_ptr[4][$];
  logic [TB_CNT_W-1:0] exp_drop = '0;

  int last_rd_cyc  = -100;
  int last_dwr_cyc = -100;
  int last_delay   = -1;
  bit hold_window  = 1'b0;

  initial begin
    bus.tx_rdy         = 4'h0;
    bus.ptr_fifo_empty = 1'b1;
    bus.ptr_fifo_dout  = '0;
    bus.data_fifo_dout = '0;
  end

  // Backend FIFO model: registered read data, one cycle after the pop.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.ptr_fifo_rd) begin
      if (pq.size() > 0) bus.ptr_fifo_dout <= pq.pop_front();
      else               underflow <= underflow + 1;
    end
    if (bus.data_fifo_rd) begin
      if (dq.size() > 0) bus.data_fifo_dout <= dq.pop_front();
      else               underflow <= underflow + 1;
    end
    bus.ptr_fifo_empty <= (pq.size() == 0);
  end

  // Output collector and protocol checks
  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < 4; p++) begin
        if (bus.tx_data_fifo_wr[p]) rx_bytes[p].push_back(bus.tx_data_fifo_din);
        if (bus.tx_ptr_fifo_wr[p])  rx_ptr[p].push_back(bus.tx_ptr_fifo_din);
      end
      if (bus.tx_ptr_fifo_wr != 4'b0) begin
        total++;
        if (bus.tx_data_fifo_wr != 4'b0 || cyc != last_dwr_cyc + 1) begin
          bad++;
          $display("FAIL ptr_after_data: ptr wr at cyc %0d, last byte wr cyc %0d, want gap 1", cyc, last_dwr_cyc);
        end
      end
      if (bus.ptr_fifo_rd) begin
        total++;
        if (bus.ptr_fifo_empty) begin
          bad++;
          $display("FAIL ptr_rd_empty: ptr_fifo_rd=1 while empty=1 at cyc %0d", cyc);
        end
      end
      if (bus.data_fifo_rd) begin
        last_rd_cyc = cyc;
        if (hold_window) begin
          total++; bad++;
          $display("FAIL wait_hold: data_fifo_rd=1 with tx_rdy=%b, want 0", bus.tx_rdy);
        end
      end
      if (bus.tx_data_fifo_wr != 4'b0) begin
        last_delay   = cyc - last_rd_cyc;
        last_dwr_cyc = cyc;
      end
    end
  end

  // Queue one descriptor plus its bytes and record what must come out.
  task automatic push_frame(input bit err, input logic [3:0] mask, input int len);
    logic [10:0] l;
    logic [7:0]  b;
    bit          drop;
    l    = 11'(len);
    drop = err || (mask == 4'b0) || (len > 1518);
    pq.push_back({err, mask, l});
    if (len == 0) begin
      if (exp_drop != '1) exp_drop++;
    end else begin
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        dq.push_back(b);
        if (!drop)
          for (int p = 0; p < 4; p++) if (mask[p]) exp_bytes[p].push_back(b);
      end
      if (drop) begin
        if (exp_drop != '1) exp_drop++;
      end else begin
        for (int p = 0; p < 4; p++) if (mask[p]) exp_ptr[p].push_back({5'b0, l});
      end
    end
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 30000 && !done; i++) begin
      @(negedge clk);
      if (pq.size() == 0 && dq.size() == 0 && !busy && bus.ptr_fifo_empty) done = 1'b1;
    end
    repeat (3) @(negedge clk);
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s timeout: pq=%0d dq=%0d busy=%b, want all drained", name, pq.size(), dq.size(), busy);
    end
  endtask

  task automatic check_out(input string name);
    for (int p = 0; p < 4; p++) begin
      int n;
      int d;
      n = (rx_bytes[p].size() < exp_bytes[p].size()) ? rx_bytes[p].size() : exp_bytes[p].size();
      d = -1;
      for (int i = 0; i < n && d < 0; i++) if (rx_bytes[p][i] !== exp_bytes[p][i]) d = i;
      if (d < 0 && rx_bytes[p].size() != exp_bytes[p].size()) d = n;
      total++;
      if (d >= 0) begin
        bad++;
        $display("FAIL %s bytes port %0d: got %0d bytes, want %0d, first diff index %0d",
                 name, p, rx_bytes[p].size(), exp_bytes[p].size(), d);
      end
      n = (rx_ptr[p].size() < exp_ptr[p].size()) ? rx_ptr[p].size() : exp_ptr[p].size();
      d = -1;
      for (int i = 0; i < n && d < 0; i++) if (rx_ptr[p][i] !== exp_ptr[p][i]) d = i;
      if (d < 0 && rx_ptr[p].size() != exp_ptr[p].size()) d = n;
      total++;
      if (d >= 0) begin
        bad++;
        $display("FAIL %s ptr port %0d: got %0d descs (first %h), want %0d (first %h)", name, p,
                 rx_ptr[p].size(), (rx_ptr[p].size() > 0) ? rx_ptr[p][0] : 16'hxxxx,
                 exp_ptr[p].size(), (exp_ptr[p].size() > 0) ? exp_ptr[p][0] : 16'hxxxx);
      end
      rx_bytes[p].delete(); exp_bytes[p].delete();
      rx_ptr[p].delete();   exp_ptr[p].delete();
    end
    total++;
    if (drop_cnt !== exp_drop) begin
      bad++;
      $display("FAIL %s drop_cnt: got %0d, want %0d", name, drop_cnt, exp_drop);
    end
    total++;
    if (underflow !== 0) begin
      bad++;
      $display("FAIL %s underflow: got %0d pops from empty FIFO, want 0", name, underflow);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    total++;
    if ({bus.ptr_fifo_rd, bus.data_fifo_rd, bus.tx_data_fifo_wr, bus.tx_data_fifo_din,
         bus.tx_ptr_fifo_wr, bus.tx_ptr_fifo_din, busy, drop_cnt} !== '0) begin
      bad++;
      $display("FAIL %s outputs: got rd=%b/%b dwr=%b din=%h pwr=%b pdin=%h busy=%b drop=%0d, want all 0",
               name, bus.ptr_fifo_rd, bus.data_fifo_rd, bus.tx_data_fifo_wr, bus.tx_data_fifo_din,
               bus.tx_ptr_fifo_wr, bus.tx_ptr_fifo_din, busy, drop_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("idle_after_reset");
  endtask

  task automatic test_unicast();
    bus.tx_rdy = 4'hF;
    push_frame(1'b0, 4'b0001, 64);
    wait_done("unicast");
    check_out("unicast");
  endtask

  task automatic test_multicast_wait();
    bus.tx_rdy = 4'b0010;
    push_frame(1'b0, 4'b1010, 60);
    hold_window = 1'b1;
    repeat (20) @(negedge clk);
    hold_window = 1'b0;
    bus.tx_rdy = 4'hF;
    wait_done("multicast");
    check_out("multicast");
    // Unselected ports not ready must not stall a unicast frame.
    bus.tx_rdy = 4'b0100;
    push_frame(1'b0, 4'b0100, 33);
    wait_done("deselected_rdy");
    check_out("deselected_rdy");
    bus.tx_rdy = 4'hF;
  endtask

  task automatic test_drops();
    push_frame(1'b1, 4'b0001, 100);
    push_frame(1'b0, 4'b0000, 80);
    push_frame(1'b0, 4'b0011, 1600);
    push_frame(1'b0, 4'b0001, 64);
    wait_done("drops");
    check_out("drops");
  endtask

  task automatic test_len0_len1();
    push_frame(1'b0, 4'b0001, 0);
    wait_done("len0");
    check_out("len0");
    push_frame(1'b0, 4'b0010, 1);
    wait_done("len1");
    total++;
    if (last_delay !== 2) begin
      bad++;
      $display("FAIL len1_latency: byte write %0d cycles after rd, want 2", last_delay);
    end
    check_out("len1");
  endtask

  task automatic test_back_to_back();
    logic [3:0] masks [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h5, 4'hA, 4'hF};
    for (int i = 0; i < 8; i++) push_frame(1'b0, masks[i], int'($urandom_range(64, 1518)));
    wait_done("back_to_back");
    check_out("back_to_back");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      push_frame(($urandom_range(0, 7) == 0), 4'($urandom), int'($urandom_range(0, 40)));
    for (int i = 0; i < 3000 && (pq.size() != 0 || dq.size() != 0); i++) begin
      @(negedge clk);
      bus.tx_rdy = 4'($urandom);
    end
    bus.tx_rdy = 4'hF;
    wait_done("random");
    check_out("random");
  endtask

  task automatic test_reset_mid_frame();
    bit seen;
    seen = 1'b0;
    push_frame(1'b0, 4'hF, 1000);
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.data_fifo_rd) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL reset_mid_frame start: data_fifo_rd got 0, want 1 within 200 cycles");
    end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("reset_mid_frame");
    pq.delete(); dq.delete();
    for (int p = 0; p < 4; p++) begin
      rx_bytes[p].delete(); exp_bytes[p].delete(); rx_ptr[p].delete(); exp_ptr[p].delete();
    end
    exp_drop = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_frame(1'b0, 4'b0110, 70);
    wait_done("after_reset");
    check_out("after_reset");
  endtask

  task automatic test_drop_sat();
    for (int i = 0; i < 20; i++) push_frame(1'b1, 4'($urandom), int'($urandom_range(0, 4)));
    wait_done("drop_sat");
    total++;
    if (drop_cnt !== 4'hF) begin
      bad++;
      $display("FAIL drop_sat: drop_cnt got %h, want f", drop_cnt);
    end
    check_out("drop_sat");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_unicast();
    test_multicast_wait();
    test_drops();
    test_len0_len1();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    test_drop_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
